systolic_ctrl: RTL and testbench
================================

# systolic_ctrl

Sequencing controller for a ROWS×COLS weight-stationary systolic array of PE tiles. It drives the array's shared preload mode line and top-row weight inputs from a weight buffer, then streams activation vectors into the array's left edge with per-row skew. It reports which bottom-row column outputs carry valid partial-sum results. It sits between the layer-level scheduler (start/done) and the PE array.

## Interface
- ROWS, 4, array rows; activation vector length
- COLS, 4, array columns; weight word length
- PORT_WIDTH, 8, activation/weight element width (signed)
- A_LAT, 4, cycles for an activation to pass one PE horizontally
- B_LAT, 4, cycles from PE activation input to its b_out; must match the MAC core configuration
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin layer; sampled only in IDLE
- num_vec  in  16  activation vectors for this layer; captured on start
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle completion pulse
- w_rd_en  out  1  weight buffer read enable
- w_rd_addr  out  $clog2(ROWS)  weight row address
- w_rd_data  in  COLS*PORT_WIDTH  weight row; 1-cycle read latency
- pe_mode  out  1  array preload mode (1 = weight shift)
- pe_weight  out  COLS*PORT_WIDTH  top-row weight inputs; equal to w_rd_data
- act_valid  in  1  activation vector valid
- act_ready  out  1  controller accepts a vector
- act_data  in  ROWS*PORT_WIDTH  element r feeds array row r
- pe_a  out  ROWS*PORT_WIDTH  skewed left-edge activations
- col_valid  out  COLS  bit c: bottom b_out of column c holds a valid result this cycle

## Operation
- FSM states: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE: start=1 captures num_vec and moves to LOAD. start while busy is ignored.
- LOAD lasts ROWS+1 cycles.
  - Read cycles 0..ROWS-1: w_rd_en=1, w_rd_addr = ROWS-1 down to 0. The bottom row is read first because weights shift down one row per mode cycle.
  - pe_mode is w_rd_en delayed by one register, so it is high for exactly ROWS cycles and aligned with the returning data.
  - Next state: RUN, or DONE if num_vec=0.
- RUN
  - act_ready=1 while accepted count < num_vec. A vector is accepted on act_valid&act_ready.
  - Element r of an accepted vector appears on pe_a row r exactly 1 + r*B_LAT cycles after acceptance.
  - Cycles without an accepted vector inject 0 into the skew lines. pe_a is 0 wherever no valid element is present.
  - After the last acceptance: act_ready=0, go to DRAIN.
- DRAIN: wait until the last accepted vector's col_valid[COLS-1] has pulsed, then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- col_valid[c] pulses exactly OUT_LAT + c*A_LAT cycles after each acceptance, where OUT_LAT = 1 + ROWS*B_LAT. Implement it as a valid-token shift register; no counting approximation.
- pe_mode is 0 outside LOAD, so array weights are never disturbed during RUN or DRAIN.
- Accepted-vector counter is 16 bits, compares against the captured num_vec, and never wraps: max 65535 vectors.

## Timing
- Reset value of every output is 0: busy, done, w_rd_en, w_rd_addr, pe_mode, act_ready, pe_a, col_valid. The FSM resets to IDLE and all skew and valid registers clear.
- With start sampled high at edge k (IDLE):
  - w_rd_en is high k+1..k+ROWS.
  - pe_mode is high k+2..k+ROWS+1.
  - RUN starts at k+ROWS+2.
- Throughput: one vector per cycle with no internal stalls. Backpressure exists only on the source side.
- done is asserted the cycle after the final col_valid[COLS-1] pulse.
- Reset asserted mid-operation clears everything immediately. No done pulse is generated for the aborted layer.

## Test plan
Parameters for all scenarios: ROWS=COLS=4, A_LAT=B_LAT=4.

1. Reset held, then released with no start -> all outputs 0, busy=0 indefinitely.
2. start at edge k with num_vec=1 -> w_rd_addr 3,2,1,0 with w_rd_en at k+1..k+4; pe_mode high k+2..k+5 with pe_weight matching buffer rows; act_ready first high at k+6.
3. Single vector {1,2,3,4} accepted at T -> pe_a rows 0..3 show 1,2,3,4 at T+1, T+5, T+9, T+13 (0 otherwise); col_valid[0..3] pulse at T+17, T+21, T+25, T+29; done at T+30, IDLE at T+31.
4. num_vec=3 with act_valid pattern 1,0,1,1 from T -> accepts at T, T+2, T+3; col_valid[0] pulses T+17, T+19, T+20 and is low at T+18; act_ready drops at T+4.
5. num_vec=0 -> full LOAD sequence, act_ready never high, done one cycle after LOAD ends; start pulsed during LOAD has no effect.
6. rst_n low during RUN after 2 of 5 vectors -> outputs 0 at once; a new start after release replays LOAD from address 3.

Source files
------------

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for a ROWS x COLS weight-stationary systolic array.
// Preloads weights bottom row first through the shared mode line, then
// streams activation vectors into the left edge with per-row skew and flags
// bottom-row columns carrying finished partial sums.

// Per-row activation skew line: a DEPTH-stage register delay.
module systolic_ctrl_skew #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [DEPTH-1:0][W-1:0] sr_q;

  // Shift the lane forward every cycle; idle cycles carry zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign dout = sr_q[DEPTH-1];
endmodule

module systolic_ctrl #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int PORT_WIDTH = 8,
  parameter int A_LAT      = 4,
  parameter int B_LAT      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [15:0]                num_vec,
  output logic                       busy,
  output logic                       done,
  output logic                       w_rd_en,
  output logic [$clog2(ROWS)-1:0]    w_rd_addr,
  input  logic [COLS*PORT_WIDTH-1:0] w_rd_data,
  output logic                       pe_mode,
  output logic [COLS*PORT_WIDTH-1:0] pe_weight,
  input  logic                       act_valid,
  output logic                       act_ready,
  input  logic [ROWS*PORT_WIDTH-1:0] act_data,
  output logic [ROWS*PORT_WIDTH-1:0] pe_a,
  output logic [COLS-1:0]            col_valid
);
  localparam int AW      = $clog2(ROWS);
  localparam int CW      = $clog2(ROWS + 1);
  localparam int OUT_LAT = 1 + ROWS * B_LAT;
  // Token travels until the last column's bottom output fires.
  localparam int TOK_LEN = OUT_LAT + (COLS - 1) * A_LAT;
  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);
  localparam logic [CW-1:0] LOAD_RD  = CW'(ROWS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          load_cnt_q, load_cnt_d;
  logic [15:0]            num_vec_q, num_vec_d;
  logic [15:0]            acc_cnt_q, acc_cnt_d;
  logic                   pe_mode_q;
  logic [TOK_LEN-1:0]     vld_pipe_q;

  logic                   rd_en_c;
  logic [AW-1:0]          rd_addr_c;
  logic                   ready_c;
  logic                   busy_c;
  logic                   done_c;
  logic                   accept;
  logic                   last_tok;

  logic [ROWS-1:0][PORT_WIDTH-1:0] act_vec;
  logic [ROWS-1:0][PORT_WIDTH-1:0] skew_in;
  logic [ROWS-1:0][PORT_WIDTH-1:0] skew_out;

  assign accept   = act_valid & ready_c;
  // Final bottom-right pulse with nothing else still in flight.
  assign last_tok = col_valid[COLS-1] & ~|vld_pipe_q[TOK_LEN-2:0];

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      load_cnt_q <= '0;
      num_vec_q  <= '0;
      acc_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      num_vec_q  <= num_vec_d;
      acc_cnt_q  <= acc_cnt_d;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    num_vec_d  = num_vec_q;
    acc_cnt_d  = acc_cnt_q;
    rd_en_c    = 1'b0;
    rd_addr_c  = '0;
    ready_c    = 1'b0;
    busy_c     = 1'b1;
    done_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_c = 1'b0;
        if (start) begin
          num_vec_d  = num_vec;
          load_cnt_d = '0;
          acc_cnt_d  = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        // Bottom row first: each mode cycle pushes weights one row down.
        if (load_cnt_q < LOAD_RD) begin
          rd_en_c    = 1'b1;
          rd_addr_c  = LAST_ROW - AW'(load_cnt_q);
          load_cnt_d = load_cnt_q + 1'b1;
        end else begin
          state_d = (num_vec_q == 16'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        ready_c = (acc_cnt_q < num_vec_q);
        if (accept) begin
          acc_cnt_d = acc_cnt_q + 16'd1;
          if (acc_cnt_q + 16'd1 == num_vec_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_tok) state_d = S_DONE;
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Mode line lags the read enable so it lines up with returning data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pe_mode_q <= 1'b0;
    else        pe_mode_q <= rd_en_c;
  end

  // One token per accepted vector; taps mark each column's bottom output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe_q <= '0;
    else        vld_pipe_q <= {vld_pipe_q[TOK_LEN-2:0], accept};
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    assign col_valid[c] = vld_pipe_q[OUT_LAT + c*A_LAT - 1];
  end

  assign act_vec = act_data;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign skew_in[r] = accept ? act_vec[r] : '0;
    systolic_ctrl_skew #(
      .W     (PORT_WIDTH),
      .DEPTH (1 + r*B_LAT)
    ) u_skew (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (skew_in[r]),
      .dout  (skew_out[r])
    );
  end

  assign pe_a      = skew_out;
  assign busy      = busy_c;
  assign done      = done_c;
  assign w_rd_en   = rd_en_c;
  assign w_rd_addr = rd_addr_c;
  assign pe_mode   = pe_mode_q;
  assign pe_weight = w_rd_data;
  assign act_ready = ready_c;
endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl with a timing scoreboard for pe_a/col_valid.
module tb_systolic_ctrl;
  localparam int R = 4, C = 4, PW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [15:0]       num_vec;
  logic              busy, done, w_rd_en, pe_mode, act_valid, act_ready;
  logic [1:0]        w_rd_addr;
  logic [C*PW-1:0]   w_rd_data, pe_weight;
  logic [R*PW-1:0]   act_data, pe_a;
  logic [C-1:0]      col_valid;

  systolic_ctrl #(.ROWS(R), .COLS(C), .PORT_WIDTH(PW), .A_LAT(4), .B_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
    .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
    .w_rd_data(w_rd_data), .pe_mode(pe_mode), .pe_weight(pe_weight),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .pe_a(pe_a), .col_valid(col_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [C*PW-1:0] wmem [R];
  initial begin
    wmem[0] = 32'hA0A1A2A3; wmem[1] = 32'hB0B1B2B3;
    wmem[2] = 32'hC0C1C2C3; wmem[3] = 32'hD0D1D2D3;
  end

  // Weight buffer with one-cycle read latency.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) w_rd_data <= '0;
    else if (w_rd_en) w_rd_data <= wmem[w_rd_addr];

  int pass_cnt = 0, chk_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    chk_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  // Scoreboard: expected arrival edges pushed on each handshake.
  typedef struct { int t; logic [PW-1:0] v; } pev_t;
  pev_t pa_q [R][$];
  int   cv_q [C][$];
  bit   mon_en = 1'b0;

  // Observed at negedge after edge cyc, values belong to edge cyc+1.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      int e;
      e = cyc + 1;
      if (act_valid && act_ready) begin
        for (int r = 0; r < R; r++) begin
          pev_t ev;
          ev.t = e + 1 + 4*r;
          ev.v = act_data[r*PW +: PW];
          pa_q[r].push_back(ev);
        end
        for (int c = 0; c < C; c++) cv_q[c].push_back(e + 17 + 4*c);
      end
      for (int r = 0; r < R; r++) begin
        if (pa_q[r].size() > 0 && pa_q[r][0].t == e) begin
          chk($sformatf("pe_a_row%0d_data", r), 64'(pe_a[r*PW +: PW]), 64'(pa_q[r][0].v));
          void'(pa_q[r].pop_front());
        end else begin
          chk($sformatf("pe_a_row%0d_idle", r), 64'(pe_a[r*PW +: PW]), 64'd0);
        end
      end
      for (int c = 0; c < C; c++) begin
        if (col_valid[c] || (cv_q[c].size() > 0 && cv_q[c][0] == e)) begin
          chk($sformatf("col_valid%0d_at", c), 64'(col_valid[c] ? e : -1),
              64'(cv_q[c].size() > 0 ? cv_q[c][0] : -2));
          if (cv_q[c].size() > 0) void'(cv_q[c].pop_front());
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},   64'(busy), 64'd0);
    chk({tag, "_done"},   64'(done), 64'd0);
    chk({tag, "_wen"},    64'(w_rd_en), 64'd0);
    chk({tag, "_waddr"},  64'(w_rd_addr), 64'd0);
    chk({tag, "_mode"},   64'(pe_mode), 64'd0);
    chk({tag, "_ready"},  64'(act_ready), 64'd0);
    chk({tag, "_pe_a"},   64'(pe_a), 64'd0);
    chk({tag, "_colv"},   64'(col_valid), 64'd0);
  endtask

  task automatic wait_ready(input int exp_at, input string tag);
    int n = 0;
    while (!act_ready && n < 20) begin nxt(); n++; end
    chk({tag, "_ready_at"}, 64'(cyc + 1), 64'(exp_at));
  endtask

  task automatic wait_done(input int exp_at, input bit no_ready, input string tag);
    int n = 0;
    while (!done && n < 80) begin
      if (no_ready) chk({tag, "_no_ready"}, 64'(act_ready), 64'd0);
      nxt(); n++;
    end
    chk({tag, "_done_at"}, 64'(done ? cyc + 1 : -1), 64'(exp_at));
    nxt();
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    for (int c = 0; c < C; c++) chk({tag, "_cv_q_empty"}, 64'(cv_q[c].size()), 64'd0);
  endtask

  initial begin
    int k, t;
    rst_n = 1'b0; start = 1'b0; num_vec = '0; act_valid = 1'b0; act_data = '0;

    // 1: reset held, then released with no start
    #3 chk_zero("rst");
    repeat (3) nxt();
    rst_n = 1'b1; mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      nxt();
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_wen", 64'(w_rd_en), 64'd0);
    end

    // 2: LOAD sequence, num_vec=1
    start = 1'b1; num_vec = 16'd1; k = cyc + 1;
    nxt(); start = 1'b0;
    chk("ld_wen0", 64'(w_rd_en), 64'd1);
    chk("ld_addr0", 64'(w_rd_addr), 64'd3);
    chk("ld_mode0", 64'(pe_mode), 64'd0);
    chk("ld_busy", 64'(busy), 64'd1);
    for (int i = 1; i < 4; i++) begin
      nxt();
      chk("ld_wen", 64'(w_rd_en), 64'd1);
      chk("ld_addr", 64'(w_rd_addr), 64'(3 - i));
      chk("ld_mode", 64'(pe_mode), 64'd1);
      chk("ld_weight", 64'(pe_weight), 64'(wmem[4 - i]));
    end
    nxt();
    chk("ld_wen_end", 64'(w_rd_en), 64'd0);
    chk("ld_mode_last", 64'(pe_mode), 64'd1);
    chk("ld_weight_last", 64'(pe_weight), 64'(wmem[0]));
    chk("ld_ready_early", 64'(act_ready), 64'd0);
    nxt();
    chk("run_mode_off", 64'(pe_mode), 64'd0);
    chk("run_ready_at", 64'(act_ready ? cyc + 1 : -1), 64'(k + 6));

    // 3: single vector {1,2,3,4}
    t = cyc + 1;
    act_valid = 1'b1; act_data = 32'h04030201;
    nxt(); act_valid = 1'b0; act_data = '0;
    chk("s3_ready_drop", 64'(act_ready), 64'd0);
    wait_done(t + 30, 1'b0, "s3");

    // 4: num_vec=3, valid pattern 1,0,1,1
    start = 1'b1; num_vec = 16'd3; k = cyc + 1;
    nxt(); start = 1'b0;
    wait_ready(k + 6, "s4");
    t = cyc + 1;
    act_valid = 1'b1; act_data = 32'h14131211;
    nxt(); chk("s4_ready1", 64'(act_ready), 64'd1);
    act_valid = 1'b0;
    nxt(); chk("s4_ready2", 64'(act_ready), 64'd1);
    act_valid = 1'b1; act_data = 32'h24232221;
    nxt(); chk("s4_ready3", 64'(act_ready), 64'd1);
    act_data = 32'h34333231;
    nxt(); act_valid = 1'b0; act_data = '0;
    chk("s4_ready_drop", 64'(act_ready), 64'd0);
    chk("s4_busy", 64'(busy), 64'd1);
    wait_done(t + 33, 1'b0, "s4");

    // 5: num_vec=0, start pulsed during LOAD ignored
    start = 1'b1; num_vec = 16'd0; k = cyc + 1;
    nxt(); start = 1'b0;
    nxt(); start = 1'b1; num_vec = 16'd7;
    nxt(); start = 1'b0;
    wait_done(k + 6, 1'b1, "s5");
    for (int i = 0; i < 4; i++) begin
      nxt();
      chk("s5_stay_idle", 64'(busy), 64'd0);
    end

    // 6: reset in RUN after 2 of 5 vectors, then replay
    start = 1'b1; num_vec = 16'd5; k = cyc + 1;
    nxt(); start = 1'b0;
    wait_ready(k + 6, "s6");
    act_valid = 1'b1; act_data = 32'h44434241;
    nxt(); act_data = 32'h54535251;
    nxt(); act_valid = 1'b0; act_data = '0;
    nxt();
    chk("s6_busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1 chk_zero("s6_rst");
    for (int r = 0; r < R; r++) pa_q[r].delete();
    for (int c = 0; c < C; c++) cv_q[c].delete();
    nxt(); nxt();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("s6_no_done", 64'(done), 64'd0);
      chk("s6_idle", 64'(busy), 64'd0);
    end
    start = 1'b1; num_vec = 16'd1; k = cyc + 1;
    nxt(); start = 1'b0;
    chk("s6_replay_wen", 64'(w_rd_en), 64'd1);
    chk("s6_replay_addr", 64'(w_rd_addr), 64'd3);
    wait_ready(k + 6, "s6r");
    t = cyc + 1;
    act_valid = 1'b1; act_data = 32'h64636261;
    nxt(); act_valid = 1'b0; act_data = '0;
    wait_done(t + 30, 1'b0, "s6r");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
